// File: rtl/ps2_keycode_sequencer.sv
// -----------------------------------------------------------------------------
// ps2_keycode_sequencer
//
// Turns the raw PS/2 scan-code byte stream into complete key events and
// queues them for a consumer.
//   - 0xE0 marks an extended key, 0xF0 marks a key release (break).
//   - 0x00 / 0xFF are keyboard error bytes: they abort any partial sequence.
//   - A prefix not followed by another byte within TIMEOUT cycles is abandoned.
// Completed events go into a small FIFO that the consumer drains over a
// valid/ready handshake.
//
// Optional feature (macro TYPEMATIC_FILTER_EN):
//   Auto-repeat suppression. The last pressed key is remembered, and repeated
//   makes of that key are not queued until it is released or another key is
//   pressed. Without the macro, every make and break is queued.
//
// Parameters:
//   FIFO_DEPTH  event FIFO entries (power of two, >= 2)
//   TIMEOUT     cycles allowed between a prefix byte and the next byte
//
// Ports:
//   clock       system clock
//   resetn      asynchronous reset, active-low
//   byte_in     scan-code byte from the PS/2 receiver
//   byte_valid  one-cycle strobe, byte_in valid
//   evt_code    head event scan code (0 when the FIFO is empty)
//   evt_ext     head event had the 0xE0 prefix
//   evt_break   head event is a key release
//   evt_valid   FIFO non-empty, head event presented
//   evt_ready   consumer accepts the head event when evt_valid=1
//   fifo_count  number of events held
//   overflow    sticky: an event was dropped because the FIFO was full
//   busy        parser is in the middle of a prefixed sequence
// -----------------------------------------------------------------------------
module ps2_keycode_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXT  = 2'd1,
        S_BRK  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Parser
    // ------------------------------------------------------------------
    state_t          state_reg, state_next;
    logic            ext_reg, ext_next;
    logic [TW-1:0]   timer_reg, timer_next;

    logic            parse_push;   // a complete event was recognised this cycle
    logic            parse_ext;
    logic            parse_brk;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
            ext_reg   <= 1'b0;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            ext_reg   <= ext_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ext_next   = ext_reg;
        timer_next = timer_reg;
        parse_push = 1'b0;
        parse_ext  = 1'b0;
        parse_brk  = 1'b0;

        if (byte_valid) begin
            timer_next = '0;
            if (byte_in == 8'h00 || byte_in == 8'hFF) begin
                // Keyboard error: abandon whatever was in progress.
                state_next = S_IDLE;
                ext_next   = 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (byte_in == 8'hE0) begin
                            state_next = S_EXT;
                            ext_next   = 1'b1;
                        end else if (byte_in == 8'hF0) begin
                            state_next = S_BRK;
                            ext_next   = 1'b0;
                        end else begin
                            parse_push = 1'b1;
                        end
                    end
                    S_EXT: begin
                        if (byte_in == 8'hE0) begin
                            state_next = S_EXT;
                        end else if (byte_in == 8'hF0) begin
                            state_next = S_BRK;  // extended flag carried into the break
                        end else begin
                            parse_push = 1'b1;
                            parse_ext  = 1'b1;
                            state_next = S_IDLE;
                            ext_next   = 1'b0;
                        end
                    end
                    S_BRK: begin
                        if (byte_in == 8'hF0) begin
                            state_next = S_BRK;
                        end else if (byte_in == 8'hE0) begin
                            // E0 after F0 is malformed; drop the sequence.
                            state_next = S_IDLE;
                            ext_next   = 1'b0;
                        end else begin
                            parse_push = 1'b1;
                            parse_ext  = ext_reg;
                            parse_brk  = 1'b1;
                            state_next = S_IDLE;
                            ext_next   = 1'b0;
                        end
                    end
                    default: begin
                        state_next = S_IDLE;
                        ext_next   = 1'b0;
                    end
                endcase
            end
        end else if (state_reg != S_IDLE) begin
            if (timer_reg == TW'(TIMEOUT - 1)) begin
                state_next = S_IDLE;
                ext_next   = 1'b0;
                timer_next = '0;
            end else begin
                timer_next = timer_reg + TW'(1);
            end
        end
    end

    assign busy = (state_reg != S_IDLE);

    // ------------------------------------------------------------------
    // Auto-repeat filter
    // ------------------------------------------------------------------
    logic push_req;

`ifdef TYPEMATIC_FILTER_EN
    logic       held_v_reg;
    logic       held_ext_reg;
    logic [7:0] held_code_reg;
    logic       held_match;

    assign held_match = held_v_reg && (held_ext_reg == parse_ext) && (held_code_reg == byte_in);
    // Breaks always go through; only a repeated make of the held key is swallowed.
    assign push_req   = parse_push && (parse_brk || !held_match);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            held_v_reg    <= 1'b0;
            held_ext_reg  <= 1'b0;
            held_code_reg <= 8'h00;
        end else if (parse_push) begin
            if (!parse_brk) begin
                held_v_reg    <= 1'b1;
                held_ext_reg  <= parse_ext;
                held_code_reg <= byte_in;
            end else if (held_match) begin
                held_v_reg <= 1'b0;
            end
        end
    end
`else
    assign push_req = parse_push;
`endif

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [9:0]    mem_reg [FIFO_DEPTH];   // {ext, brk, code}
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          overflow_reg;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic [9:0]    head;

    assign full      = (count_reg == (AW + 1)'(FIFO_DEPTH));
    assign evt_valid = (count_reg != '0);
    assign pop       = evt_valid && evt_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
    assign push_ok   = push_req && (!full || pop);

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= {parse_ext, parse_brk, byte_in};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (push_req && full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign head       = evt_valid ? mem_reg[rd_ptr_reg] : 10'd0;
    assign evt_ext    = head[9];
    assign evt_break  = head[8];
    assign evt_code   = head[7:0];
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;

endmodule
